// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatch controller: fetches a command word, launches one of N_OPS
// execution units, forwards partial/final results to an output FIFO and reports status.
module instr_dispatch_fsm #(
  parameter int WORD_SIZE = 16,
  parameter int OP_W      = 8,
  parameter int N_OPS     = 4,
  parameter int TIMEOUT   = 1024,
  localparam int SEL_W    = (N_OPS > 1) ? $clog2(N_OPS) : 1,
  localparam int ARGB_W   = WORD_SIZE - OP_W - 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic                 cmd_valid_i,
  input  logic [WORD_SIZE-1:0] cmd_word_i,
  output logic                 cmd_rd_o,
  output logic [OP_W-1:0]      instr_o,
  output logic [2:0]           arg_a_o,
  output logic [ARGB_W-1:0]    arg_b_o,
  output logic [N_OPS-1:0]     unit_start_o,
  input  logic [N_OPS-1:0]     unit_done_i,
  input  logic [N_OPS-1:0]     unit_partial_i,
  input  logic                 out_full_i,
  output logic                 out_wr_o,
  output logic [SEL_W-1:0]     out_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_o,
  input  logic                 abort_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [OP_W:0]    N_OPS_L  = (OP_W + 1)'(N_OPS);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_WAIT, S_FETCH_DONE, S_LAUNCH, S_WAIT,
    S_PART_WR, S_FINAL_WR, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_OPCODE  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ABORT   = 2'b11
  } err_e;

  localparam logic [1:0] MODE_FETCH = 2'b00;
  localparam logic [1:0] MODE_EXEC  = 2'b01;

  state_e            state_q;
  err_e              err_q;
  logic [OP_W-1:0]   instr_q;
  logic [2:0]        arg_a_q;
  logic [ARGB_W-1:0] arg_b_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic [CNT_W-1:0]  cnt_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_OK;
      instr_q   <= '0;
      arg_a_q   <= '0;
      arg_b_q   <= '0;
      out_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q <= ERR_OK;
            if (mode_i == MODE_FETCH) begin
              state_q <= S_FETCH_WAIT;
            end else if (mode_i == MODE_EXEC) begin
              if ({1'b0, instr_q} < N_OPS_L) begin
                state_q   <= S_LAUNCH;
                out_sel_q <= SEL_W'(instr_q);
              end else begin
                state_q <= S_ERR;
                err_q   <= ERR_OPCODE;
              end
            end
          end
        end
        S_FETCH_WAIT: begin
          if (cmd_valid_i) begin
            instr_q <= cmd_word_i[OP_W-1:0];
            arg_a_q <= cmd_word_i[OP_W+2:OP_W];
            arg_b_q <= cmd_word_i[WORD_SIZE-1:OP_W+3];
            state_q <= S_FETCH_DONE;
          end
        end
        S_LAUNCH: begin
          cnt_q <= '0;
          if (abort_i) begin
            state_q <= S_ERR;
            err_q   <= ERR_ABORT;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Only the launched unit's handshakes matter; the counter never wraps.
          if (abort_i) begin
            state_q <= S_ERR;
            err_q   <= ERR_ABORT;
          end else if (unit_done_i[out_sel_q]) begin
            state_q <= S_FINAL_WR;
          end else if (unit_partial_i[out_sel_q]) begin
            state_q <= S_PART_WR;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERR;
            err_q   <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PART_WR: begin
          if (abort_i) begin
            state_q <= S_ERR;
            err_q   <= ERR_ABORT;
          end else if (!out_full_i) begin
            state_q <= S_WAIT;
          end
        end
        S_FINAL_WR: begin
          if (abort_i) begin
            state_q <= S_ERR;
            err_q   <= ERR_ABORT;
          end else if (!out_full_i) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          err_q   <= ERR_OK;
          state_q <= S_IDLE;
        end
        S_FETCH_DONE, S_ERR: state_q <= S_IDLE;
        default:             state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake strobes follow their inputs within the state; an abort suppresses the write.
  assign cmd_rd_o     = (state_q == S_FETCH_WAIT) && cmd_valid_i;
  assign out_wr_o     = ((state_q == S_PART_WR) || (state_q == S_FINAL_WR)) &&
                        !out_full_i && !abort_i;
  assign unit_start_o = (state_q == S_LAUNCH) ? (N_OPS'(1) << out_sel_q) : '0;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_FETCH_DONE) || (state_q == S_DONE) ||
                        (state_q == S_ERR);
  assign err_o        = err_q;
  assign instr_o      = instr_q;
  assign arg_a_o      = arg_a_q;
  assign arg_b_o      = arg_b_q;
  assign out_sel_o    = out_sel_q;

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Scoreboard bench for instr_dispatch_fsm: stimulus queues expected output events,
// a forked monitor pops and compares each event the DUT presents.
module tb_instr_dispatch_fsm;

  localparam int WORD_SIZE = 16;
  localparam int OP_W      = 8;
  localparam int N_OPS     = 4;
  localparam int TIMEOUT   = 16;

  typedef enum logic [1:0] {EV_CMD, EV_START, EV_WR, EV_DONE} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic [31:0] val;
    int          dt;   // required cycles since previous event, -1 = don't care
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        cmd_valid_i;
  logic [15:0] cmd_word_i;
  logic        cmd_rd_o;
  logic [7:0]  instr_o;
  logic [2:0]  arg_a_o;
  logic [4:0]  arg_b_o;
  logic [3:0]  unit_start_o;
  logic [3:0]  unit_done_i;
  logic [3:0]  unit_partial_i;
  logic        out_full_i;
  logic        out_wr_o;
  logic [1:0]  out_sel_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;
  logic        abort_i;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_dispatch_fsm #(
    .WORD_SIZE(WORD_SIZE), .OP_W(OP_W), .N_OPS(N_OPS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .cmd_valid_i(cmd_valid_i), .cmd_word_i(cmd_word_i), .cmd_rd_o(cmd_rd_o),
    .instr_o(instr_o), .arg_a_o(arg_a_o), .arg_b_o(arg_b_o),
    .unit_start_o(unit_start_o), .unit_done_i(unit_done_i),
    .unit_partial_i(unit_partial_i), .out_full_i(out_full_i), .out_wr_o(out_wr_o),
    .out_sel_o(out_sel_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .abort_i(abort_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_done(input logic [1:0] e, input logic [7:0] i,
                                          input logic [2:0] a, input logic [4:0] b);
    return {14'b0, e, i, a, b};
  endfunction

  function automatic void push(input ev_e k, input logic [31:0] v, input int dt);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.dt   = dt;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    int          cyc  = 0;
    int          last = 0;
    int          seq  = 0;
    exp_t        e;
    ev_e         k;
    logic [31:0] v;
    bit          have;
    forever begin
      @(negedge clk);
      cyc++;
      have = 1'b1;
      k    = EV_CMD;
      v    = '0;
      if (cmd_rd_o)                  begin k = EV_CMD;   v = '0; end
      else if (unit_start_o != '0)   begin k = EV_START; v = 32'(unit_start_o); end
      else if (out_wr_o)             begin k = EV_WR;    v = 32'(out_sel_o); end
      else if (done_o)               begin k = EV_DONE;  v = mk_done(err_o, instr_o, arg_a_o, arg_b_o); end
      else have = 1'b0;
      if (have) begin
        seq++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_event#%0d: got unexpected %s val=%h, expected no event",
                   seq, k.name(), v);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.val != v || (e.dt >= 0 && (cyc - last) != e.dt)) begin
            n_bad++;
            $display("FAIL sb_event#%0d: got %s val=%h dt=%0d, expected %s val=%h dt=%0d",
                     seq, k.name(), v, cyc - last, e.kind.name(), e.val, e.dt);
          end
        end
        last = cyc;
      end
    end
  endtask

  task automatic do_fetch(input logic [15:0] w, input int delay, input logic [31:0] exp_done);
    push(EV_CMD, '0, -1);
    push(EV_DONE, exp_done, 1);
    start_i = 1'b1;
    mode_i  = 2'b00;
    step(1);
    start_i = 1'b0;
    if (delay > 1) step(delay - 1);
    cmd_valid_i = 1'b1;
    cmd_word_i  = w;
    step(1);
    cmd_valid_i = 1'b0;
    step(2);
  endtask

  task automatic start_exec();
    start_i = 1'b1;
    mode_i  = 2'b01;
    step(1);
    start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start_i = 1'b0; mode_i = 2'b00; cmd_valid_i = 1'b0; cmd_word_i = '0;
    unit_done_i = '0; unit_partial_i = '0; out_full_i = 1'b0; abort_i = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    step(2);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_cmd_rd", 32'(cmd_rd_o), 0);
    check("rst_out_wr", 32'(out_wr_o), 0);
    check("rst_unit_start", 32'(unit_start_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_instr", 32'(instr_o), 0);
    check("rst_out_sel", 32'(out_sel_o), 0);
    rst = 1'b1;
    step(2);

    // FETCH with cmd_valid 3 cycles after start
    do_fetch(16'h2B02, 3, mk_done(2'b00, 8'h02, 3'd3, 5'd5));
    check("fetch_idle_busy", 32'(busy_o), 0);

    // EXEC instr=1: two partials then final
    do_fetch(16'h0001, 1, mk_done(2'b00, 8'h01, 3'd0, 5'd0));
    push(EV_START, 32'h2, -1);
    push(EV_WR, 32'h1, 2);
    push(EV_WR, 32'h1, 2);
    push(EV_WR, 32'h1, 2);
    push(EV_DONE, mk_done(2'b00, 8'h01, 3'd0, 5'd0), 1);
    start_exec();
    step(1); unit_partial_i = 4'b0010;
    step(1); unit_partial_i = 4'b0000;
    step(1); unit_partial_i = 4'b0010;
    step(1); unit_partial_i = 4'b0000;
    step(1); unit_done_i    = 4'b0010;
    step(1); unit_done_i    = 4'b0000;
    step(3);
    check("exec_out_sel_held", 32'(out_sel_o), 1);

    // Backpressure: out_full for 5 cycles in FINAL_WR
    push(EV_START, 32'h2, -1);
    push(EV_WR, 32'h1, -1);
    push(EV_DONE, mk_done(2'b00, 8'h01, 3'd0, 5'd0), 1);
    start_exec();
    step(1); out_full_i = 1'b1; unit_done_i = 4'b0010;
    step(1); unit_done_i = 4'b0000;
    step(2);
    check("bp_stall_no_wr", 32'(out_wr_o), 0);
    check("bp_stall_busy", 32'(busy_o), 1);
    step(3); out_full_i = 1'b0;
    step(3);

    // Bad opcode
    do_fetch(16'h0007, 1, mk_done(2'b00, 8'h07, 3'd0, 5'd0));
    push(EV_DONE, mk_done(2'b01, 8'h07, 3'd0, 5'd0), -1);
    start_exec();
    step(2);
    check("bad_op_err_held", 32'(err_o), 1);
    check("bad_op_idle", 32'(busy_o), 0);
    start_i = 1'b1; mode_i = 2'b10;
    step(1);
    start_i = 1'b0;
    check("ignored_mode_idle", 32'(busy_o), 0);
    check("ignored_mode_clears_err", 32'(err_o), 0);

    // Timeout with only foreign unit handshakes
    do_fetch(16'h0000, 1, mk_done(2'b00, 8'h00, 3'd0, 5'd0));
    push(EV_START, 32'h1, -1);
    push(EV_DONE, mk_done(2'b10, 8'h00, 3'd0, 5'd0), 17);
    start_exec();
    step(1); unit_done_i = 4'b0100; unit_partial_i = 4'b1000;
    step(10);
    check("timeout_still_waiting", 32'(busy_o), 1);
    step(7); unit_done_i = '0; unit_partial_i = '0;
    check("timeout_err", 32'(err_o), 2);
    step(1);

    // Abort in WAIT
    push(EV_START, 32'h1, -1);
    push(EV_DONE, mk_done(2'b11, 8'h00, 3'd0, 5'd0), 3);
    start_exec();
    step(2); abort_i = 1'b1;
    step(1); abort_i = 1'b0;
    step(2);
    check("abort_wait_err", 32'(err_o), 3);

    // Abort in PART_WR suppresses the write
    push(EV_START, 32'h1, -1);
    push(EV_DONE, mk_done(2'b11, 8'h00, 3'd0, 5'd0), 3);
    start_exec();
    step(1); unit_partial_i = 4'b0001;
    step(1); unit_partial_i = 4'b0000; abort_i = 1'b1;
    step(1); abort_i = 1'b0;
    step(2);

    // Abort ignored in IDLE
    abort_i = 1'b1;
    step(2);
    check("abort_idle_ignored", 32'(busy_o), 0);
    abort_i = 1'b0;

    // Reset in PART_WR
    do_fetch(16'hA901, 1, mk_done(2'b00, 8'h01, 3'd1, 5'd21));
    push(EV_START, 32'h2, -1);
    start_exec();
    step(1); unit_partial_i = 4'b0010;
    step(1); unit_partial_i = 4'b0000; out_full_i = 1'b0; rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_o), 0);
    check("rst_mid_out_wr", 32'(out_wr_o), 0);
    check("rst_mid_done", 32'(done_o), 0);
    check("rst_mid_instr", 32'(instr_o), 0);
    check("rst_mid_arg_a", 32'(arg_a_o), 0);
    check("rst_mid_arg_b", 32'(arg_b_o), 0);
    check("rst_mid_out_sel", 32'(out_sel_o), 0);
    step(2);
    rst = 1'b1;
    step(5);

    // Drain: every expected event must have been seen
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d events outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
